// File: rtl/preg_release_queue.sv
// Buffers freed physical register tags from commit and returns them to the free list in order.
// Illegal tags are dropped, flagged in a sticky error, and counted.
module preg_release_queue #(
  parameter int DEPTH    = 16,
  parameter int PREG_MIN = 32,
  parameter int PREG_MAX = 159
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rel_valid,
  input  logic [7:0]                 rel_preg,
  output logic                       rel_ready,
  input  logic                       hold,
  output logic                       fl_valid,
  output logic [7:0]                 fl_data,
  input  logic                       fl_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       idle,
  output logic                       err,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0]    TAG_MIN = 8'(PREG_MIN);
  localparam logic [7:0]    TAG_MAX = 8'(PREG_MAX);

  function automatic logic tag_legal(input logic [7:0] tag);
    tag_legal = (tag >= TAG_MIN) && (tag <= TAG_MAX);
  endfunction

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic accept_s, push_s, drop_s, pop_s;

  // Handshake decode and next-state computation; reset masks both handshakes.
  always_comb begin
    rel_ready  = (count_q < DEPTH_C);
    accept_s   = rel_valid && rel_ready && !reset;
    push_s     = accept_s && tag_legal(rel_preg);
    drop_s     = accept_s && !tag_legal(rel_preg);
    fl_valid   = (count_q != {CW{1'b0}}) && !hold;
    pop_s      = fl_valid && fl_ready && !reset;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    err_d      = err_q || drop_s;
    drop_cnt_d = drop_cnt_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (drop_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Output decode from registered state.
  always_comb begin
    count    = count_q;
    err      = err_q;
    drop_cnt = drop_cnt_q;
    idle     = (count_q == {CW{1'b0}}) && !accept_s;
    if (count_q == {CW{1'b0}}) begin
      fl_data = 8'h00;
    end else begin
      fl_data = mem_q[rd_ptr_q];
    end
  end

  // Control state; buffered entries are discarded by clearing pointers and count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      err_q      <= 1'b0;
      drop_cnt_q <= 8'h00;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Tag storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= rel_preg;
    end
  end

endmodule
